// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration handshake: requests/ack in, grants and status out.
interface bus_arbiter_if;
  logic [3:0] BR;
  logic       ACK;
  logic [3:0] BG;
  logic       BUS_BUSY;
  logic [1:0] OWNER;
  logic       TIMEOUT_ERR;

  // Arbiter side
  modport master (
    input  BR, ACK,
    output BG, BUS_BUSY, OWNER, TIMEOUT_ERR
  );

  // Requester / observer side
  modport slave (
    output BR, ACK,
    input  BG, BUS_BUSY, OWNER, TIMEOUT_ERR
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus controllers with a dead turnaround
// cycle between owners and a watchdog that revokes unacknowledged grants.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          BUS_CLK,
  input  logic          RST,
  bus_arbiter_if.master bus
);

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_GRANT = 4'b0010;
  localparam logic [3:0] S_HOLD  = 4'b0100;
  localparam logic [3:0] S_TURN  = 4'b1000;

  logic [3:0] state_q, state_d;
  logic [3:0] bg_q, bg_d;
  logic       busy_q, busy_d;
  logic [1:0] owner_q, owner_d;
  logic       terr_q, terr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       owner_req;

  assign owner_req = bus.BR[owner_q];

  // Winner search: first set request after the last winner, wrapping mod 4
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_vld && bus.BR[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    terr_d  = 1'b0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      // IDLE and TURN arbitrate identically; TURN only exists to force BG low
      S_IDLE, S_TURN: begin
        state_d = S_IDLE;
        bg_d    = '0;
        busy_d  = 1'b0;
        if (win_vld) begin
          state_d = S_GRANT;
          bg_d    = 4'b0001 << win_idx;
          busy_d  = 1'b1;
          owner_d = win_idx;
          ptr_d   = win_idx;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (!owner_req) begin
          state_d = S_TURN;
          bg_d    = '0;
          busy_d  = 1'b0;
        end else if (bus.ACK) begin
          state_d = S_HOLD;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_TURN;
          bg_d    = '0;
          busy_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (!owner_req) begin
          state_d = S_TURN;
          bg_d    = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        bg_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output flops; reset drops the grant without a clock edge
  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      bg_q    <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.BG          = bg_q;
  assign bus.BUS_BUSY    = busy_q;
  assign bus.OWNER       = owner_q;
  assign bus.TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized run against a behavioural model.
module tb_bus_arbiter;

  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .BUS_CLK (clk),
    .RST     (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] br;
    logic       ack;
    logic [3:0] bg;
    logic       busy;
    logic [1:0] owner;
    logic       err;
  } vec_t;

  vec_t vecs[15];

  // Behavioural model state
  bit m_owned;
  bit m_acked;
  int m_age;
  int m_owner;
  int m_last;
  bit m_err;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    bus.BR = '0;
    bus.ACK = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rr_pick(input logic [3:0] br, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (br[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_acked = 0; m_age = 0; m_owner = 0; m_last = 3; m_err = 0;
  endtask

  // Apply the arbitration rules for one clock edge with the given inputs
  task automatic model_edge(input logic [3:0] br, input logic ack);
    m_err = 0;
    if (m_owned) begin
      if (!br[m_owner]) m_owned = 0;
      else if (!m_acked) begin
        if (ack) m_acked = 1;
        else if (m_age == int'(TO) - 1) begin m_owned = 0; m_err = 1; end
        else m_age++;
      end
    end else if (br != 0) begin
      m_owner = rr_pick(br, m_last);
      m_last  = m_owner;
      m_owned = 1; m_acked = 0; m_age = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0] nb;
    logic [3:0] exp_bg;
    int hi;

    //              br      ack   bg      busy  own   err
    vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0}; // DMA granted
    vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0}; // ACK -> HOLD
    vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0}; // ACK low ignored in HOLD
    vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0}; // drop -> TURN
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0}; // IDLE
    vecs[5]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0}; // DC granted
    vecs[6]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0}; // HOLD
    vecs[7]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0}; // late MEM not granted
    vecs[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[9]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0}; // DC drops -> TURN
    vecs[10] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0}; // MEM ahead of IC
    vecs[11] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0}; // ACK+drop -> TURN
    vecs[12] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0}; // IC granted
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0}; // TURN
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0}; // IDLE

    rst_n = 1'b0;
    bus.BR = '0;
    bus.ACK = 1'b0;
    #12;
    chk("reset_bg",    8'(bus.BG), 8'h0);
    chk("reset_busy",  8'(bus.BUS_BUSY), 8'h0);
    chk("reset_owner", 8'(bus.OWNER), 8'h0);
    chk("reset_err",   8'(bus.TIMEOUT_ERR), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      bus.BR  = vecs[i].br;
      bus.ACK = vecs[i].ack;
      step();
      chk($sformatf("vec%0d_bg", i),    8'(bus.BG),          8'(vecs[i].bg));
      chk($sformatf("vec%0d_busy", i),  8'(bus.BUS_BUSY),    8'(vecs[i].busy));
      chk($sformatf("vec%0d_owner", i), 8'(bus.OWNER),       8'(vecs[i].owner));
      chk($sformatf("vec%0d_err", i),   8'(bus.TIMEOUT_ERR), 8'(vecs[i].err));
    end

    // Watchdog: IC never acknowledged
    bus.BR = 4'b0001; bus.ACK = 1'b0;
    step();
    hi = 0;
    while (bus.BG[0] && hi < 40) begin
      hi++;
      chk("wd_no_err_during_grant", 8'(bus.TIMEOUT_ERR), 8'h0);
      step();
    end
    chk("wd_grant_cycles", 8'(hi), 8'(TO));
    chk("wd_err_pulse",    8'(bus.TIMEOUT_ERR), 8'h1);
    chk("wd_turn_bg",      8'(bus.BG), 8'h0);
    step();
    chk("wd_regrant_bg",   8'(bus.BG), 8'h1);
    chk("wd_err_cleared",  8'(bus.TIMEOUT_ERR), 8'h0);
    bus.BR = 4'b0000;
    step(); step();

    // ACK on the same edge the watchdog would expire
    bus.BR = 4'b0001; bus.ACK = 1'b0;
    step();
    for (int i = 0; i < int'(TO) - 1; i++) step();
    chk("ackexp_still_granted", 8'(bus.BG), 8'h1);
    bus.ACK = 1'b1;
    step();
    chk("ackexp_bg",  8'(bus.BG), 8'h1);
    chk("ackexp_err", 8'(bus.TIMEOUT_ERR), 8'h0);
    bus.ACK = 1'b0;
    step(); step();
    chk("ackexp_hold_bg", 8'(bus.BG), 8'h1);
    bus.BR = 4'b0000;
    step(); step();

    // Asynchronous reset while DMA is in HOLD
    bus.BR = 4'b0100;
    step();
    bus.ACK = 1'b1;
    step();
    chk("hold_before_rst", 8'(bus.BG), 8'h4);
    bus.ACK = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bg",    8'(bus.BG), 8'h0);
    chk("arst_busy",  8'(bus.BUS_BUSY), 8'h0);
    chk("arst_owner", 8'(bus.OWNER), 8'h0);
    chk("arst_err",   8'(bus.TIMEOUT_ERR), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness with all four requesting
    bus.BR = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr%0d_owner", g), 8'(bus.OWNER), 8'(g % 4));
      chk($sformatf("rr%0d_bg", g),    8'(bus.BG),    8'(4'b0001 << (g % 4)));
      bus.ACK = 1'b1;
      step();
      bus.ACK = 1'b0;
      step(); step(); step();
      bus.BR = 4'b1111 & ~(4'b0001 << (g % 4));
      step();
      chk($sformatf("rr%0d_gap_bg", g),   8'(bus.BG), 8'h0);
      chk($sformatf("rr%0d_gap_busy", g), 8'(bus.BUS_BUSY), 8'h0);
      bus.BR = 4'b1111;
      step();
    end

    // Randomized run against the behavioural model
    do_reset();
    model_reset();
    nb = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_owned && i == m_owner) begin
          if ($urandom_range(0, 11) == 0) nb[i] = ~nb[i];
        end else if ($urandom_range(0, 3) == 0) begin
          nb[i] = ~nb[i];
        end
      end
      bus.BR  = nb;
      bus.ACK = ($urandom_range(0, 7) == 0);
      model_edge(nb, bus.ACK);
      step();
      exp_bg = m_owned ? (4'b0001 << m_owner) : 4'b0000;
      chk("rand_bg",    8'(bus.BG),          8'(exp_bg));
      chk("rand_busy",  8'(bus.BUS_BUSY),    8'(m_owned));
      chk("rand_owner", 8'(bus.OWNER),       8'(m_owner));
      chk("rand_err",   8'(bus.TIMEOUT_ERR), 8'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter for the shared system bus (D, A, SIZE, RW). It grants bus mastership to one of four bus controllers: I-cache, D-cache, DMA and main memory. Each controller raises BR and owns the bus drivers while it holds BG. The arbiter rotates priority round-robin, holds a grant until the owner releases BR, and inserts one dead turnaround cycle between owners so tristate drivers never overlap. A watchdog reclaims the bus from a master whose transfer is never acknowledged.

## Interface
Parameters:
- TIMEOUT, 15: number of GRANT-state cycles without ACK before the grant is revoked; legal range 1..255.

Ports:
- BUS_CLK  in  1  bus clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- BR  in  4  bus requests, level-held by requesters; [0] IC, [1] DC, [2] DMA, [3] main memory.
- ACK  in  1  wired-OR of all controllers' ACK_OUT; the addressed slave has accepted the transfer.
- BG  out  4  bus grants, one-hot or zero, registered; index matches BR.
- BUS_BUSY  out  1  high in GRANT and HOLD, registered.
- OWNER  out  2  index of the current or last granted requester, registered.
- TIMEOUT_ERR  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- State register, one-hot: IDLE, GRANT, HOLD, TURN. There is an 8-bit watchdog counter CNT and a 2-bit round-robin pointer PTR (last winner).
- Winner selection (combinational): the first set BR bit searching PTR+1, PTR+2, PTR+3, PTR+4 (mod 4). The winner is valid only if BR≠0.
- IDLE: BG=0. If BR≠0 at an edge, go to GRANT, set BG[w]=1, OWNER=w, PTR=w, CNT=0. Otherwise stay in IDLE.
- GRANT: BG[OWNER] held. Conditions are evaluated at each edge in this priority order:
  - BR[OWNER]=0: go to TURN and clear BG. An ACK on the same edge is ignored.
  - ACK=1: go to HOLD.
  - CNT=TIMEOUT-1: go to TURN, clear BG, and pulse TIMEOUT_ERR for the next cycle.
  - Otherwise: CNT=CNT+1.
- HOLD: BG[OWNER] held while BR[OWNER]=1. The level of ACK is irrelevant here; multi-cycle bursts may drop and re-raise ACK. When BR[OWNER]=0 is sampled, go to TURN and clear BG.
- TURN: BG=0 and BUS_BUSY=0 for exactly one cycle. At the next edge:
  - If BR≠0, go to GRANT with a new winner using the updated PTR. The same requester can win only if no other BR bit is set.
  - Otherwise go to IDLE.
- Requests from non-owners are never granted while the bus is owned. They are evaluated at the next IDLE or TURN edge.
- BR[OWNER] may stay high through TURN because the requester wants the bus again. It then competes normally and loses to any other set request.
- CNT saturates logic is not needed because the exit happens at TIMEOUT-1. CNT is only meaningful in GRANT.
- Reset (RST=0, asynchronous): state=IDLE, BG=0000, BUS_BUSY=0, OWNER=0, TIMEOUT_ERR=0, CNT=0, PTR=3. With PTR=3, IC has highest priority for the first arbitration.
- Reset asserted mid-transfer drops BG immediately, without waiting for a clock edge.

## Timing
- Grant latency: BR sampled high at edge k in IDLE, so BG is high from edge k (visible in cycle k+1).
- Release: BR[OWNER] sampled low at edge m, so BG is low after edge m. TURN is cycle m+1, and the earliest next BG rises at edge m+1.
- Minimum gap between two different owners' BG: one full cycle.
- Watchdog: with no ACK, BG stays high for exactly TIMEOUT cycles. TIMEOUT_ERR is high for the one cycle after the revoke edge.
- All outputs come straight from flops; there are no combinational paths from BR or ACK to any output.

## Test plan
- Reset then single request: assert BR=0100 (DMA) after release of RST. BG=0100 one edge later; BUS_BUSY=1; OWNER=2. ACK at the next edge moves to HOLD. Drop BR: BG=0000 after that edge, with one TURN cycle, then IDLE.
- Round-robin fairness: hold BR=1111 continuously, with each owner ACKing and then dropping BR 3 cycles later. Grant order is IC, DC, DMA, MEM, IC. A single-cycle BG=0000 gap appears between every pair of grants.
- Watchdog: TIMEOUT=15, BR=0001 with ACK never asserted. BG[0] is high for exactly 15 cycles, followed by a TIMEOUT_ERR pulse of 1 cycle. With BR still high and no other requests, IC is re-granted after the TURN cycle.
- Simultaneous edge events:
  - ACK and counter expiry on the same edge: the FSM goes to HOLD and there is no TIMEOUT_ERR.
  - ACK and BR drop on the same edge in GRANT: the FSM goes to TURN.
- Late requester: the DC owns the bus in HOLD and BR[3] rises. No BG[3] is issued until the DC drops BR. MEM is then granted immediately after TURN, with PTR rotation placing MEM ahead of IC.
- Asynchronous reset mid-HOLD: pull RST low between edges. BG, BUS_BUSY, OWNER and TIMEOUT_ERR go to 0 without a clock edge. After release, IC wins a BR=1111 contest.
